// File: rtl/counter_pkg.sv
// Shared types for the programmable counter.
// Holds the run-state encoding and count direction constants.
package counter_pkg;

    typedef enum logic [1:0] {
        CNT_IDLE,
        CNT_RUN,
        CNT_DONE
    } cnt_state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/prog_counter_tick_gen.sv
// Prescaler for prog_counter.
// Emits one tick every PRESC_DIV enabled cycles; freezes while en is low.
module tick_gen #(
    parameter int PRESC_DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int PW = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(PRESC_DIV - 1);

    logic [PW-1:0] ps_d;
    logic [PW-1:0] ps_q;

    assign tick = en && (ps_q == PS_LAST);

    // Next prescaler value: clear wins, wrap on tick, advance when enabled.
    always_comb begin
        ps_d = ps_q;
        if (clr) begin
            ps_d = '0;
        end else if (tick) begin
            ps_d = '0;
        end else if (en) begin
            ps_d = ps_q + 1'b1;
        end
    end

    // Prescaler register.
    always_ff @(posedge clk) begin
        if (reset) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_d;
        end
    end

endmodule

// File: rtl/prog_counter.sv
// Programmable up/down counter with modulus, prescaler, load and one-shot.
// Define PROG_COUNTER_CMP_EN to add the cmp_val/match comparator.
module prog_counter
    import counter_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int MAX_COUNT = 999,
    parameter int PRESC_DIV = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             start,
    input  logic             stop,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dir,
    input  logic             oneshot,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             busy
`ifdef PROG_COUNTER_CMP_EN
    ,
    input  logic [WIDTH-1:0] cmp_val,
    output logic             match
`endif
);

    localparam logic [WIDTH-1:0] MAXV    = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH + 1)'(MAX_COUNT);

    cnt_state_t       state_d;
    cnt_state_t       state_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;
    logic             tc_d;
    logic             tc_q;
    logic             run;
    logic             tick;
    logic             clr_ps;
    logic             upd;

    assign run  = (state_q == CNT_RUN);
    assign q    = q_q;
    assign tc   = tc_q;
    assign busy = run;

    tick_gen #(
        .PRESC_DIV(PRESC_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .reset(reset),
        .clr  (clr_ps),
        .en   (run && en),
        .tick (tick)
    );

    // Next state and count: load > stop > start > tick.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        tc_d    = 1'b0;
        clr_ps  = 1'b0;
        upd     = 1'b0;
        if (load) begin
            q_d    = ({1'b0, load_val} > MAX_EXT) ? MAXV : load_val;
            clr_ps = 1'b1;
            upd    = 1'b1;
            if (state_q == CNT_DONE) begin
                state_d = CNT_IDLE;
            end
        end else if (stop && run) begin
            state_d = CNT_IDLE;
        end else if (start && !run) begin
            state_d = CNT_RUN;
            clr_ps  = 1'b1;
        end else if (tick) begin
            upd = 1'b1;
            if (dir == DIR_UP) begin
                if ({1'b0, q_q} < MAX_EXT) begin
                    q_d = q_q + 1'b1;
                end else begin
                    tc_d = 1'b1;
                    if (oneshot) begin
                        state_d = CNT_DONE;
                    end else begin
                        q_d = '0;
                    end
                end
            end else begin
                if (q_q != '0) begin
                    q_d = q_q - 1'b1;
                end else begin
                    tc_d = 1'b1;
                    if (oneshot) begin
                        state_d = CNT_DONE;
                    end else begin
                        q_d = MAXV;
                    end
                end
            end
        end
    end

    // State, count and terminal-count registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CNT_IDLE;
            q_q     <= '0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            tc_q    <= tc_d;
        end
    end

`ifdef PROG_COUNTER_CMP_EN
    logic match_d;
    logic match_q;

    assign match = match_q;

    // Match fires when a load or tick lands the count on cmp_val.
    always_comb begin
        match_d = upd && (q_d == cmp_val);
    end

    // Match pulse register.
    always_ff @(posedge clk) begin
        if (reset) begin
            match_q <= 1'b0;
        end else begin
            match_q <= match_d;
        end
    end
`else
    logic unused_upd;
    assign unused_upd = upd;
`endif

endmodule
